// File: rtl/regf_sb.sv
// Scoreboarded register file: combinational multi-port reads with
// writeback bypass, per-register busy bits and a one-shot clear sweep.
module regf_sb #(
  parameter int DW  = 32,
  parameter int AW  = 5,
  parameter int NRD = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NRD*AW-1:0] i_rd_idx,
  output logic [NRD*DW-1:0] o_rd_val,
  output logic [NRD-1:0]    o_rd_busy,
  input  logic              i_wb_en,
  input  logic [AW-1:0]     i_wb_reg,
  input  logic [DW-1:0]     i_wb_val,
  input  logic              i_rsv_en,
  input  logic [AW-1:0]     i_rsv_reg,
  input  logic              i_clr,
  output logic              o_clr_busy
);

  localparam int NREG = 1 << AW;

  typedef enum logic {
    IDLE,
    SWEEP
  } state_t;

  state_t          state;
  logic [AW-1:0]   cnt;
  logic [DW-1:0]   vals [NREG];
  logic [NREG-1:0] bsy;

  logic wb_ok;
  logic rsv_ok;
  logic idle;

  assign idle   = (state == IDLE);
  assign wb_ok  = i_wb_en && (i_wb_reg != '0);
  assign rsv_ok = i_rsv_en && (i_rsv_reg != '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      o_clr_busy <= 1'b0;
      bsy        <= '0;
      for (int i = 0; i < NREG; i++) begin
        vals[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (wb_ok) begin
            vals[i_wb_reg] <= i_wb_val;
            bsy[i_wb_reg]  <= 1'b0;
          end
          // Ordered after the writeback so a same-register reserve wins.
          if (rsv_ok) begin
            bsy[i_rsv_reg] <= 1'b1;
          end
          if (i_clr) begin
            state      <= SWEEP;
            cnt        <= AW'(1);
            o_clr_busy <= 1'b1;
          end
        end
        SWEEP: begin
          vals[cnt] <= '0;
          bsy[cnt]  <= 1'b0;
          if (cnt == '1) begin
            state      <= IDLE;
            o_clr_busy <= 1'b0;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        default: begin
          state      <= IDLE;
          o_clr_busy <= 1'b0;
        end
      endcase
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] idx;
    logic          byp;
    logic          nz;

    assign idx = i_rd_idx[k*AW +: AW];
    assign nz  = (idx != '0);
    // Bypass is suppressed in reset so outputs read zero immediately.
    assign byp = !i_rst && idle && wb_ok && (i_wb_reg == idx);

    assign o_rd_val[k*DW +: DW] = byp ? i_wb_val
                                : nz  ? vals[idx]
                                : '0;
    assign o_rd_busy[k] = !byp && nz && bsy[idx];
  end

endmodule

// File: tb/tb_regf_sb.sv
// Directed self-checking bench for regf_sb (DW=32, AW=5, NRD=4).
module tb_regf_sb;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NRD = 4;

  logic              clk;
  logic              rst;
  logic [NRD*AW-1:0] rd_idx;
  logic [NRD*DW-1:0] rd_val;
  logic [NRD-1:0]    rd_busy;
  logic              wb_en;
  logic [AW-1:0]     wb_reg;
  logic [DW-1:0]     wb_val;
  logic              rsv_en;
  logic [AW-1:0]     rsv_reg;
  logic              clr;
  logic              clr_busy;

  int checks;
  int errors;

  regf_sb #(.DW(DW), .AW(AW), .NRD(NRD)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rd_idx   (rd_idx),
    .o_rd_val   (rd_val),
    .o_rd_busy  (rd_busy),
    .i_wb_en    (wb_en),
    .i_wb_reg   (wb_reg),
    .i_wb_val   (wb_val),
    .i_rsv_en   (rsv_en),
    .i_rsv_reg  (rsv_reg),
    .i_clr      (clr),
    .o_clr_busy (clr_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rv(input int k);
    return rd_val[k*DW +: DW];
  endfunction

  task automatic set_rd(input int k, input logic [AW-1:0] r);
    rd_idx[k*AW +: AW] = r;
  endtask

  task automatic quiet();
    wb_en  = 1'b0;
    rsv_en = 1'b0;
    clr    = 1'b0;
  endtask

  task automatic do_wb(input logic [AW-1:0] r, input logic [DW-1:0] v);
    @(negedge clk);
    quiet();
    wb_en  = 1'b1;
    wb_reg = r;
    wb_val = v;
  endtask

  task automatic test_reset();
    #1;
    for (int k = 0; k < NRD; k++) begin
      checks++;
      if (rv(k) !== '0 || rd_busy[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_port%0d: val=%h busy=%b want 0/0", k, rv(k), rd_busy[k]);
      end
    end
    checks++;
    if (clr_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_clr_busy: got %b want 0", clr_busy);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    do_wb(5'd5, 32'hDEADBEEF);
    @(negedge clk);
    quiet();
    set_rd(0, 5'd5);
    set_rd(1, 5'd5);
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (rv(k) !== 32'hDEADBEEF || rd_busy[k] !== 1'b0) begin
        errors++;
        $display("FAIL wr_rd_port%0d: val=%h busy=%b want deadbeef/0", k, rv(k), rd_busy[k]);
      end
    end
  endtask

  task automatic test_r0_and_bypass();
    do_wb(5'd0, 32'h1234);
    set_rd(0, 5'd0);
    #1;
    checks++;
    if (rv(0) !== '0 || rd_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL r0_wr_same: val=%h busy=%b want 0/0", rv(0), rd_busy[0]);
    end
    @(negedge clk);
    quiet();
    #1;
    checks++;
    if (rv(0) !== '0 || rd_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL r0_after: val=%h busy=%b want 0/0", rv(0), rd_busy[0]);
    end
    do_wb(5'd7, 32'hAA);
    set_rd(0, 5'd7);
    #1;
    checks++;
    if (rv(0) !== 32'hAA) begin
      errors++;
      $display("FAIL r7_bypass: got %h want aa", rv(0));
    end
    @(negedge clk);
    quiet();
    #1;
    checks++;
    if (rv(0) !== 32'hAA) begin
      errors++;
      $display("FAIL r7_stored: got %h want aa", rv(0));
    end
  endtask

  task automatic test_reserve();
    @(negedge clk);
    quiet();
    rsv_en  = 1'b1;
    rsv_reg = 5'd3;
    set_rd(0, 5'd3);
    @(negedge clk);
    quiet();
    #1;
    checks++;
    if (rd_busy[0] !== 1'b1) begin
      errors++;
      $display("FAIL rsv_busy: got %b want 1", rd_busy[0]);
    end
    do_wb(5'd3, 32'h55);
    #1;
    checks++;
    if (rd_busy[0] !== 1'b0 || rv(0) !== 32'h55) begin
      errors++;
      $display("FAIL rsv_bypass: val=%h busy=%b want 55/0", rv(0), rd_busy[0]);
    end
    @(negedge clk);
    quiet();
    #1;
    checks++;
    if (rd_busy[0] !== 1'b0 || rv(0) !== 32'h55) begin
      errors++;
      $display("FAIL rsv_wb_stored: val=%h busy=%b want 55/0", rv(0), rd_busy[0]);
    end
    do_wb(5'd3, 32'h55);
    rsv_en  = 1'b1;
    rsv_reg = 5'd3;
    @(negedge clk);
    quiet();
    #1;
    checks++;
    if (rd_busy[0] !== 1'b1 || rv(0) !== 32'h55) begin
      errors++;
      $display("FAIL rsv_wins: val=%h busy=%b want 55/1", rv(0), rd_busy[0]);
    end
    do_wb(5'd6, 32'h66);
    rsv_en  = 1'b1;
    rsv_reg = 5'd4;
    @(negedge clk);
    quiet();
    set_rd(0, 5'd4);
    set_rd(1, 5'd6);
    #1;
    checks++;
    if (rd_busy[0] !== 1'b1 || rv(1) !== 32'h66 || rd_busy[1] !== 1'b0) begin
      errors++;
      $display("FAIL rsv_wb_diff: busy4=%b val6=%h busy6=%b want 1/66/0", rd_busy[0], rv(1), rd_busy[1]);
    end
  endtask

  task automatic test_multi_port();
    do_wb(5'd1, 32'h11);
    do_wb(5'd2, 32'h22);
    do_wb(5'd2, 32'h2222);
    set_rd(0, 5'd1);
    set_rd(1, 5'd2);
    set_rd(2, 5'd0);
    set_rd(3, 5'd1);
    #1;
    checks++;
    if (rv(0) !== 32'h11 || rv(1) !== 32'h2222 || rv(2) !== '0 || rv(3) !== 32'h11) begin
      errors++;
      $display("FAIL multi_port: %h %h %h %h want 11 2222 0 11", rv(0), rv(1), rv(2), rv(3));
    end
    checks++;
    if (rd_busy !== 4'b0000) begin
      errors++;
      $display("FAIL multi_busy: got %b want 0000", rd_busy);
    end
    @(negedge clk);
    quiet();
    #1;
    checks++;
    if (rv(1) !== 32'h2222) begin
      errors++;
      $display("FAIL multi_stored: got %h want 2222", rv(1));
    end
  endtask

  task automatic test_sweep();
    int cyc;
    for (int i = 1; i < 32; i++) begin
      do_wb(AW'(i), 32'h01010101 * i);
    end
    @(negedge clk);
    quiet();
    rsv_en  = 1'b1;
    rsv_reg = 5'd9;
    set_rd(0, 5'd9);
    set_rd(1, 5'd20);
    @(negedge clk);
    quiet();
    #1;
    checks++;
    if (rd_busy[0] !== 1'b1 || rv(1) !== 32'h14141414) begin
      errors++;
      $display("FAIL pre_sweep: busy9=%b val20=%h want 1/14141414", rd_busy[0], rv(1));
    end
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    quiet();
    set_rd(0, 5'd2);
    cyc = 0;
    while (clr_busy === 1'b1 && cyc < 40) begin
      cyc++;
      wb_en   = 1'b1;
      wb_reg  = 5'd2;
      wb_val  = 32'hFFFF;
      rsv_en  = 1'b1;
      rsv_reg = 5'd2;
      clr     = (cyc == 10);
      if (cyc == 5) begin
        #1;
        checks++;
        if (rv(0) !== '0 || rd_busy[0] !== 1'b0 || rv(1) !== 32'h14141414) begin
          errors++;
          $display("FAIL mid_sweep: val2=%h busy2=%b val20=%h want 0/0/14141414", rv(0), rd_busy[0], rv(1));
        end
      end
      @(negedge clk);
    end
    quiet();
    checks++;
    if (cyc != 31) begin
      errors++;
      $display("FAIL sweep_len: got %0d cycles want 31", cyc);
    end
    #1;
    for (int i = 0; i < 32; i += 4) begin
      for (int k = 0; k < NRD; k++) set_rd(k, AW'(i + k));
      #1;
      checks++;
      if (rd_val !== '0 || rd_busy !== '0) begin
        errors++;
        $display("FAIL post_sweep_r%0d: val=%h busy=%b want 0/0", i, rd_val, rd_busy);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    do_wb(5'd25, 32'hCAFE);
    @(negedge clk);
    quiet();
    rsv_en  = 1'b1;
    rsv_reg = 5'd26;
    @(negedge clk);
    quiet();
    clr = 1'b1;
    @(negedge clk);
    quiet();
    set_rd(0, 5'd25);
    set_rd(1, 5'd26);
    for (int c = 1; c < 10; c++) @(negedge clk);
    #1;
    checks++;
    if (clr_busy !== 1'b1 || rv(0) !== 32'hCAFE || rd_busy[1] !== 1'b1) begin
      errors++;
      $display("FAIL sweep10_pre: clr=%b val25=%h busy26=%b want 1/cafe/1", clr_busy, rv(0), rd_busy[1]);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (rd_val !== '0 || rd_busy !== '0 || clr_busy !== 1'b0) begin
      errors++;
      $display("FAIL async_rst: val=%h busy=%b clr=%b want 0/0/0", rd_val, rd_busy, clr_busy);
    end
    #1;
    rst    = 1'b0;
    wb_en  = 1'b1;
    wb_reg = 5'd25;
    wb_val = 32'hBEEF;
    @(posedge clk);
    #1;
    quiet();
    #1;
    checks++;
    if (rv(0) !== 32'hBEEF || clr_busy !== 1'b0) begin
      errors++;
      $display("FAIL post_rst_wr: val=%h clr=%b want beef/0", rv(0), clr_busy);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    rd_idx  = '0;
    wb_reg  = '0;
    wb_val  = '0;
    rsv_reg = '0;
    quiet();
    test_reset();
    test_write_read();
    test_r0_and_bypass();
    test_reserve();
    test_multi_port();
    test_sweep();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
